// File: rtl/lift_call_arbiter.sv
// lift_call_arbiter: latches hall-call buttons into pending flags, clears them on
//   arrival, and picks one call per cycle as a 3-bit request code for the lift FSM.
// Latency: press -> pending 1 edge (DEBOUNCE_CYC+1 with debounce), pending -> req_code 1 edge.
// Backpressure: none; req_code is re-evaluated every cycle from the registered pending flags.
//
// Optional feature macro: LIFT_CALL_DEBOUNCE_EN (per-button debounce counters).
//
// Ports:
//   clk        single clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   btn[5:0]   hall buttons, bit0..5 = 1U,2U,3U,2D,3D,4D, active high
//   floor[1:0] current car floor (0..3 = floors 1..4)
//   arrive     1-cycle pulse: car stopped at floor, doors opening
//   dir[1:0]   FSM direction: 00 UP, 01 DOWN, 10/11 STAY
//   req_code   selected call: 001 1U, 010 2U, 011 3U, 110 2D, 111 3D, 100 4D, 000 none
//   req_valid  1 when req_code != 000
//   pending    registered pending-call flags, same bit order as btn
module lift_call_arbiter #(
  parameter int DEBOUNCE_CYC = 4,
  parameter int CNT_W        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] btn,
  input  logic [1:0] floor,
  input  logic       arrive,
  input  logic [1:0] dir,
  output logic [2:0] req_code,
  output logic       req_valid,
  output logic [5:0] pending
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  state_t     state;
  state_t     state_d;
  state_t     sel_tgt;
  logic [5:0] qual;
  logic [5:0] clr;
  logic [2:0] sel_code;
  logic [2:0] code_d;
  logic       valid_d;

  // Counter must be able to reach DEBOUNCE_CYC without wrapping.
  generate
    if ((2 ** CNT_W) <= DEBOUNCE_CYC) begin : g_cnt_w_too_small
      $error("lift_call_arbiter: CNT_W too narrow for DEBOUNCE_CYC");
    end
  endgenerate

  // Button qualification
`ifdef LIFT_CALL_DEBOUNCE_EN
  logic [5:0][CNT_W-1:0] cnt;

  // Saturating at all-ones keeps a long press from re-hitting DEBOUNCE_CYC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (!btn[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != {CNT_W{1'b1}}) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    qual = '0;
    for (int i = 0; i < 6; i++) begin
      qual[i] = (cnt[i] == CNT_W'(DEBOUNCE_CYC));
    end
  end
`else
  always_comb begin
    qual = btn;
  end
`endif

  // Clear mask: calls at the arrival floor that the current sweep serves.
  // Floors 0 and 3 each carry a single call, so they clear in any state.
  always_comb begin
    clr = '0;
    if (arrive) begin
      case (floor)
        2'd0: clr[0] = 1'b1;
        2'd3: clr[5] = 1'b1;
        default: begin
          if (state != ST_DOWN) clr[floor] = 1'b1;
          if (state != ST_UP)   clr[{1'b0, floor} + 3'd2] = 1'b1;
        end
      endcase
    end
  end

  // Set then clear, so clear wins on a same-cycle collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending | qual) & ~clr;
    end
  end

  // Candidate search over registered pending. Up call bit f sits at floor f;
  // down call bit 3+k sits at floor k+1.
  logic       up_hi_vld, up_lo_vld, dn_lo_vld, dn_hi_vld;
  logic [1:0] up_hi_f, up_lo_f, dn_lo_f, dn_hi_f;

  always_comb begin
    up_hi_vld = 1'b0; up_hi_f = '0;   // lowest up-call at or above car
    up_lo_vld = 1'b0; up_lo_f = '0;   // lowest up-call anywhere
    dn_lo_vld = 1'b0; dn_lo_f = '0;   // highest down-call at or below car
    dn_hi_vld = 1'b0; dn_hi_f = '0;   // highest down-call anywhere
    for (int f = 2; f >= 0; f--) begin
      if (pending[f]) begin
        up_lo_vld = 1'b1;
        up_lo_f   = 2'(f);
        if (2'(f) >= floor) begin
          up_hi_vld = 1'b1;
          up_hi_f   = 2'(f);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (pending[3 + k]) begin
        dn_hi_vld = 1'b1;
        dn_hi_f   = 2'(k + 1);
        if (2'(k + 1) <= floor) begin
          dn_lo_vld = 1'b1;
          dn_lo_f   = 2'(k + 1);
        end
      end
    end
  end

  // Code = {is_down, floor+1} truncated to 2 bits, which maps 4D onto 100.
  function automatic logic [2:0] up_code(input logic [1:0] f);
    logic [1:0] n;
    n = f + 2'd1;
    return {1'b0, n};
  endfunction

  function automatic logic [2:0] dn_code(input logic [1:0] f);
    logic [1:0] n;
    n = f + 2'd1;
    return {1'b1, n};
  endfunction

  // Selection and the sweep direction it implies.
  always_comb begin
    sel_code = 3'b000;
    sel_tgt  = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (up_lo_vld) begin
          sel_code = up_hi_vld ? up_code(up_hi_f) : up_code(up_lo_f);
          sel_tgt  = ST_UP;
        end else if (dn_hi_vld) begin
          sel_code = dn_lo_vld ? dn_code(dn_lo_f) : dn_code(dn_hi_f);
          sel_tgt  = ST_DOWN;
        end
      end
      ST_UP: begin
        if (up_hi_vld) begin
          sel_code = up_code(up_hi_f);
          sel_tgt  = ST_UP;
        end else if (dn_hi_vld) begin
          sel_code = dn_code(dn_hi_f);
          sel_tgt  = ST_DOWN;
        end else if (up_lo_vld) begin
          sel_code = up_code(up_lo_f);
          sel_tgt  = ST_UP;
        end
      end
      ST_DOWN: begin
        if (dn_lo_vld) begin
          sel_code = dn_code(dn_lo_f);
          sel_tgt  = ST_DOWN;
        end else if (up_lo_vld) begin
          sel_code = up_code(up_lo_f);
          sel_tgt  = ST_UP;
        end else if (dn_hi_vld) begin
          sel_code = dn_code(dn_hi_f);
          sel_tgt  = ST_DOWN;
        end
      end
      default: begin
        sel_code = 3'b000;
        sel_tgt  = ST_IDLE;
      end
    endcase
  end

  // FSM process 1: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // FSM process 2: next state. A moving car (dir UP/DOWN) pins the sweep
  // direction while calls remain; STAY leaves the selection rules in charge.
  always_comb begin
    state_d = sel_tgt;
    if (pending != 6'd0) begin
      if (dir == 2'b00) begin
        state_d = ST_UP;
      end else if (dir == 2'b01) begin
        state_d = ST_DOWN;
      end
    end
  end

  // FSM process 3: outputs (registered below)
  always_comb begin
    code_d  = sel_code;
    valid_d = (sel_code != 3'b000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_code  <= 3'b000;
      req_valid <= 1'b0;
    end else begin
      req_code  <= code_d;
      req_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_lift_call_arbiter.sv
// tb_lift_call_arbiter: random and directed stimulus against a call-list reference model.
// Latency: model advances one step per rising edge, outputs compared on the falling edge.
// Backpressure: none.
module tb_lift_call_arbiter;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] btn;
  logic [1:0] floor;
  logic       arrive;
  logic [1:0] dir;
  logic [2:0] req_code;
  logic       req_valid;
  logic [5:0] pending;

  always #5 clk = ~clk;

  lift_call_arbiter #(.DEBOUNCE_CYC(DEB), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .floor     (floor),
    .arrive    (arrive),
    .dir       (dir),
    .req_code  (req_code),
    .req_valid (req_valid),
    .pending   (pending)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: list of six calls, each with a floor and a direction.
  int         call_floor[6] = '{0, 1, 2, 1, 2, 3};
  logic [2:0] call_code[6]  = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b100};
  logic [5:0] m_pend;
  int         m_state;       // 0 idle, 1 sweeping up, 2 sweeping down
  logic [2:0] m_code;
  int         run_len[6];    // consecutive sampled-high cycles per button

  task automatic m_reset();
    m_pend  = '0;
    m_state = 0;
    m_code  = 3'b000;
    for (int i = 0; i < 6; i++) run_len[i] = 0;
  endtask

  // Index of the pending call in [first..last] with floor in [lo..hi],
  // choosing the lowest or highest floor; -1 if none.
  function automatic int pick(input logic [5:0] p, input int first, input int last,
                              input bit low, input int lo, input int hi);
    int best = -1;
    for (int i = first; i <= last; i++) begin
      if (p[i] && call_floor[i] >= lo && call_floor[i] <= hi) begin
        if (best < 0) best = i;
        else if (low && call_floor[i] < call_floor[best]) best = i;
        else if (!low && call_floor[i] > call_floor[best]) best = i;
      end
    end
    return best;
  endfunction

  task automatic m_step();
    logic [5:0] q, clr;
    int fl, uh, ul, dl, dh, sel, tgt;
    fl = int'(floor);
    for (int i = 0; i < 6; i++) begin
`ifdef LIFT_CALL_DEBOUNCE_EN
      q[i] = (run_len[i] == DEB);
`else
      q[i] = btn[i];
`endif
      clr[i] = arrive && (call_floor[i] == fl) &&
               (fl == 0 || fl == 3 || m_state == 0 ||
                (i < 3 && m_state == 1) || (i >= 3 && m_state == 2));
    end
    uh = pick(m_pend, 0, 2, 1'b1, fl, 3);
    ul = pick(m_pend, 0, 2, 1'b1, 0, 3);
    dl = pick(m_pend, 3, 5, 1'b0, 0, fl);
    dh = pick(m_pend, 3, 5, 1'b0, 0, 3);
    sel = -1;
    tgt = 0;
    if (m_state == 0) begin
      if (ul >= 0)      begin sel = (uh >= 0) ? uh : ul; tgt = 1; end
      else if (dh >= 0) begin sel = (dl >= 0) ? dl : dh; tgt = 2; end
    end else if (m_state == 1) begin
      if (uh >= 0)      begin sel = uh; tgt = 1; end
      else if (dh >= 0) begin sel = dh; tgt = 2; end
      else if (ul >= 0) begin sel = ul; tgt = 1; end
    end else begin
      if (dl >= 0)      begin sel = dl; tgt = 2; end
      else if (ul >= 0) begin sel = ul; tgt = 1; end
      else if (dh >= 0) begin sel = dh; tgt = 2; end
    end
    if (m_pend != 0 && dir == 2'b00) tgt = 1;
    else if (m_pend != 0 && dir == 2'b01) tgt = 2;
    m_code  = (sel < 0) ? 3'b000 : call_code[sel];
    m_pend  = (m_pend | q) & ~clr;
    m_state = tgt;
    for (int i = 0; i < 6; i++) run_len[i] = btn[i] ? run_len[i] + 1 : 0;
  endtask

  // Called on a falling edge: drive, step the model at the rising edge,
  // compare on the next falling edge.
  task automatic cyc(input logic [5:0] b, input logic [1:0] f, input logic a, input logic [1:0] d);
    btn = b; floor = f; arrive = a; dir = d;
    @(posedge clk);
    if (rst_n) m_step();
    @(negedge clk);
    chk("pending", 32'(pending), 32'(m_pend));
    chk("req_code", 32'(req_code), 32'(m_code));
    chk("req_valid", 32'(req_valid), 32'(m_code != 3'b000));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn = '0; arrive = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Asynchronous reset landing between edges; outputs must drop at once.
  task automatic async_rst(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_pend"}, 32'(pending), 32'd0);
    chk({tag, "_code"}, 32'(req_code), 32'd0);
    chk({tag, "_vld"}, 32'(req_valid), 32'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [5:0] rb;
  logic [5:0] tog;

  initial begin
    rst_n = 1'b0; btn = 6'h3F; floor = 2'd0; arrive = 1'b0; dir = 2'b10;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_code", 32'(req_code), 32'd0);
    chk("rst_vld", 32'(req_valid), 32'd0);
    rst_n = 1'b1;
    cyc(6'h3F, 2'd0, 1'b0, 2'b10);
    cyc(6'h00, 2'd0, 1'b0, 2'b10);

`ifndef LIFT_CALL_DEBOUNCE_EN
    // Single 2U press from floor 1, then served on arrival at floor 2.
    do_reset();
    cyc(6'b000010, 2'd0, 1'b0, 2'b10);
    chk("t2_pend", 32'(pending), 32'h02);
    cyc(6'b000000, 2'd0, 1'b0, 2'b10);
    chk("t2_code", 32'(req_code), 32'h2);
    chk("t2_vld", 32'(req_valid), 32'h1);
    cyc(6'b000000, 2'd1, 1'b1, 2'b10);
    chk("t2_clr", 32'(pending), 32'h0);
    cyc(6'b000000, 2'd1, 1'b0, 2'b10);
    chk("t2_none", 32'(req_code), 32'h0);

    // Sweep: 1U, 3U, 4D pending with the car at floor 2.
    do_reset();
    cyc(6'b100101, 2'd1, 1'b0, 2'b10);
    cyc(6'b000000, 2'd1, 1'b0, 2'b10);
    cyc(6'b000000, 2'd1, 1'b0, 2'b10);
    chk("t3_3u", 32'(req_code), 32'h3);
    cyc(6'b000000, 2'd2, 1'b1, 2'b10);
    cyc(6'b000000, 2'd2, 1'b0, 2'b10);
    chk("t3_4d", 32'(req_code), 32'h4);
    cyc(6'b000000, 2'd3, 1'b1, 2'b10);
    cyc(6'b000000, 2'd3, 1'b0, 2'b10);
    chk("t3_1u", 32'(req_code), 32'h1);
    cyc(6'b000000, 2'd3, 1'b0, 2'b10);
    chk("t3_1u_hold", 32'(req_code), 32'h1);

    // Collision: 3U pressed in the arrival cycle at floor 3 while sweeping up.
    do_reset();
    cyc(6'b010100, 2'd2, 1'b0, 2'b10);
    cyc(6'b000000, 2'd2, 1'b0, 2'b10);
    cyc(6'b000100, 2'd2, 1'b1, 2'b10);
    chk("t4_clr_wins", 32'(pending), 32'h10);
    cyc(6'b000000, 2'd2, 1'b0, 2'b10);
    chk("t4_3d_kept", 32'(pending), 32'h10);
`else
    // Debounce: short glitch ignored, long press latched exactly once.
    do_reset();
    repeat (3) cyc(6'b100000, 2'd0, 1'b0, 2'b10);
    repeat (3) cyc(6'b000000, 2'd0, 1'b0, 2'b10);
    chk("deb_glitch", 32'(pending[5]), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      cyc(6'b100000, 2'd0, 1'b0, 2'b10);
      if (k == 4) chk("deb_early", 32'(pending[5]), 32'd0);
      if (k == 5) chk("deb_set", 32'(pending[5]), 32'd1);
    end
    cyc(6'b100000, 2'd3, 1'b1, 2'b10);
    cyc(6'b000000, 2'd3, 1'b0, 2'b10);
    chk("deb_once", 32'(pending[5]), 32'd0);
`endif

    // Mid-cycle reset with three calls pending.
    do_reset();
    cyc(6'b100011, 2'd1, 1'b0, 2'b10);
    cyc(6'b100011, 2'd1, 1'b0, 2'b10);
    repeat (DEB + 2) cyc(6'b100011, 2'd1, 1'b0, 2'b10);
    chk("t6_pre", 32'(pending), 32'h23);
    btn = 6'h3F;
    async_rst("t6");
    cyc(6'h00, 2'd0, 1'b0, 2'b10);

    // Random traffic: buttons toggle sparsely so presses span several cycles.
    rb = '0;
    for (int n = 0; n < 1500; n++) begin
      tog = '0;
      for (int i = 0; i < 6; i++) tog[i] = ($urandom_range(0, 5) == 0);
      rb = rb ^ tog;
      cyc(rb, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
          2'($urandom_range(0, 3)));
      if ($urandom_range(0, 199) == 0) async_rst("rnd_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
